// File: rtl/d2pram_pipe.sv
// d2pram_pipe: simple dual-port (one write, one read) synchronous SRAM model.
// Per-byte write enables, read latency of 1 or 2 cycles, read-valid/error
// flags, and a selectable same-address read-during-write policy.
//
// Handshake: there is no ready. A read is accepted on every rising edge where
// ren=1 and rst=0. Exactly RD_LAT cycles later, rvalid pulses high for one
// cycle with its rdata/rerr. rerr is only meaningful while rvalid=1.
// Writes have no response.
module d2pram_pipe #(
    parameter int WIDTH    = 32,
    parameter int SIZE     = 4096,
    parameter int RD_LAT   = 1,
    parameter int RDW_MODE = 0,
    parameter int AW       = (SIZE > 1) ? $clog2(SIZE) : 1,
    parameter int MW       = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [MW-1:0]    wmask,
    input  logic             ren,
    input  logic [AW-1:0]    raddr,
    output logic             rvalid,
    output logic [WIDTH-1:0] rdata,
    output logic             rerr
);

    // One extra bit so SIZE itself is representable when SIZE is a power of two.
    localparam logic [AW:0] SIZE_L = (AW + 1)'(SIZE);

    logic [WIDTH-1:0] mem [SIZE];

    logic             w_in_range;
    logic             r_in_range;
    logic [WIDTH-1:0] rd_word;

    // First read stage registers.
    logic             s1_valid;
    logic             s1_err;
    logic [WIDTH-1:0] s1_data;

    assign w_in_range = ({1'b0, waddr} < SIZE_L);
    assign r_in_range = ({1'b0, raddr} < SIZE_L);

    // Byte-masked write; memory is deliberately untouched by reset.
    always_ff @(posedge clk) begin
        if (!rst && wen && w_in_range) begin
            for (int b = 0; b < MW; b++) begin
                if (wmask[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Word captured by an accepted read: stored word, optionally merged with a
    // same-cycle write to the same address, forced to zero when out of range.
    always_comb begin
        rd_word = '0;
        if (r_in_range) begin
            rd_word = mem[raddr];
            if (RDW_MODE == 1 && wen && (waddr == raddr)) begin
                for (int b = 0; b < MW; b++) begin
                    if (wmask[b]) begin
                        rd_word[8*b +: 8] = wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    // First read stage; data only reloads on an accepted read so it holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= ren;
            s1_err   <= ren && !r_in_range;
            if (ren) begin
                s1_data <= rd_word;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic             s2_valid;
            logic             s2_err;
            logic [WIDTH-1:0] s2_data;

            // Second read stage; captured data is never touched by later writes.
            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_valid <= 1'b0;
                    s2_err   <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    s2_err   <= s1_err;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign rvalid = s2_valid;
            assign rerr   = s2_err;
            assign rdata  = s2_data;
        end else begin : g_lat1
            assign rvalid = s1_valid;
            assign rerr   = s1_err;
            assign rdata  = s1_data;
        end
    endgenerate

endmodule
